// File: rtl/raster_dispatch.sv
// 1-to-LANES job distributor: round-robin or least-occupied steering into
// per-lane FIFOs with valid/ready on both sides, synchronous flush and occupancy outputs.
module raster_dispatch #(
  parameter int unsigned WIDTH = 371,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MODE  = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  vld_in,
  input  logic [WIDTH-1:0]                      data_in,
  output logic                                  rdy_in,
  output logic [LANES-1:0]                      vld_out,
  output logic [LANES*WIDTH-1:0]                data_out,
  input  logic [LANES-1:0]                      rdy_out,
  output logic [$clog2(LANES)-1:0]              dispatch_lane,
  output logic [LANES*($clog2(DEPTH)+1)-1:0]    lane_occ,
  output logic                                  idle
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam logic [OW-1:0] OccFull = OW'(DEPTH);

  logic [OW-1:0]    occ_q    [LANES];
  logic [PW-1:0]    wr_ptr_q [LANES];
  logic [PW-1:0]    rd_ptr_q [LANES];
  logic [WIDTH-1:0] mem_q    [LANES][DEPTH];
  logic [LW-1:0]    rr_ptr_q;
  logic [LW-1:0]    sel;
  logic             accept;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;

  // Lane choice depends only on registered state, never on vld_in or rdy_out.
  if (MODE == 0) begin : g_rr
    assign sel = rr_ptr_q;
  end else begin : g_lo
    logic [OW-1:0] best;
    always_comb begin
      sel  = '0;
      best = occ_q[0];
      for (int i = 1; i < LANES; i++) begin
        if (occ_q[i] < best) begin
          best = occ_q[i];
          sel  = LW'(i);
        end
      end
    end
  end

  assign dispatch_lane = sel;
  assign rdy_in        = (occ_q[sel] != OccFull) && !flush && !rst;
  assign accept        = vld_in && rdy_in;

  always_comb begin
    push     = '0;
    pop      = '0;
    vld_out  = '0;
    data_out = '0;
    lane_occ = '0;
    idle     = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      vld_out[i]                = (occ_q[i] != '0);
      data_out[i*WIDTH +: WIDTH] = mem_q[i][rd_ptr_q[i]];
      lane_occ[i*OW +: OW]      = occ_q[i];
      push[i]                   = accept && (sel == LW'(i));
      pop[i]                    = vld_out[i] && rdy_out[i];
      if (occ_q[i] != '0) idle = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        occ_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else if (flush) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        occ_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        if (rr_ptr_q == LW'(LANES - 1)) rr_ptr_q <= '0;
        else                            rr_ptr_q <= rr_ptr_q + 1'b1;
      end
      for (int i = 0; i < LANES; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        if (push[i] && !pop[i])      occ_q[i] <= occ_q[i] + 1'b1;
        else if (pop[i] && !push[i]) occ_q[i] <= occ_q[i] - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the occupancy counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= data_in;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_chk
    a_occ_range: assert property (@(posedge clk) disable iff (rst) occ_q[g] <= OccFull);
    a_no_overrun: assert property (@(posedge clk) disable iff (rst) push[g] |-> occ_q[g] != OccFull);
  end

endmodule

// File: tb/tb_raster_dispatch.sv
// Bench for raster_dispatch: one round-robin and one least-occupied instance on shared
// stimulus, each compared every cycle against a queue-based model, plus directed sequences.
module tb_raster_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        vld_in;
  logic [7:0]  data_in;
  logic [3:0]  rdy_out;
  logic        rdy_s  [2];
  logic [3:0]  vo_s   [2];
  logic [31:0] do_s   [2];
  logic [1:0]  dl_s   [2];
  logic [11:0] occ_s  [2];
  logic        idle_s [2];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue per (mode, lane), plus the round-robin pointer.
  logic [7:0] mq [8][$];
  int         rr [2];

  always #5 clk = ~clk;

  raster_dispatch #(.WIDTH(8), .LANES(4), .DEPTH(4), .MODE(0)) u_rr (
    .clk(clk), .rst(rst), .flush(flush), .vld_in(vld_in), .data_in(data_in),
    .rdy_in(rdy_s[0]), .vld_out(vo_s[0]), .data_out(do_s[0]), .rdy_out(rdy_out),
    .dispatch_lane(dl_s[0]), .lane_occ(occ_s[0]), .idle(idle_s[0])
  );

  raster_dispatch #(.WIDTH(8), .LANES(4), .DEPTH(4), .MODE(1)) u_lo (
    .clk(clk), .rst(rst), .flush(flush), .vld_in(vld_in), .data_in(data_in),
    .rdy_in(rdy_s[1]), .vld_out(vo_s[1]), .data_out(do_s[1]), .rdy_out(rdy_out),
    .dispatch_lane(dl_s[1]), .lane_occ(occ_s[1]), .idle(idle_s[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_occ(int m, int l);
    return mq[m*4+l].size();
  endfunction

  function automatic int m_disp(int m);
    int best;
    if (m == 0) return rr[0];
    best = 0;
    for (int l = 1; l < 4; l++) if (m_occ(m, l) < m_occ(m, best)) best = l;
    return best;
  endfunction

  function automatic logic m_rdy(int m);
    return (m_occ(m, m_disp(m)) < 4) && !flush && !rst;
  endfunction

  function automatic logic [11:0] occ4(int a0, int a1, int a2, int a3);
    return {a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mq[i].delete();
    rr[0] = 0;
    rr[1] = 0;
  endtask

  task automatic model_check();
    int any;
    for (int m = 0; m < 2; m++) begin
      any = 0;
      chk($sformatf("m%0d rdy_in", m), 32'(rdy_s[m]), 32'(m_rdy(m)));
      chk($sformatf("m%0d dispatch_lane", m), 32'(dl_s[m]), m_disp(m));
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("m%0d lane%0d occ", m, l), 32'(occ_s[m][l*3 +: 3]), m_occ(m, l));
        chk($sformatf("m%0d lane%0d vld_out", m, l), 32'(vo_s[m][l]), 32'(m_occ(m, l) > 0));
        if (m_occ(m, l) > 0) begin
          any = 1;
          chk($sformatf("m%0d lane%0d head", m, l), 32'(do_s[m][l*8 +: 8]),
              32'(mq[m*4+l][0]));
        end
      end
      chk($sformatf("m%0d idle", m), 32'(idle_s[m]), 32'(any == 0));
    end
  endtask

  task automatic model_update();
    int d;
    logic acc;
    for (int m = 0; m < 2; m++) begin
      d   = m_disp(m);
      acc = vld_in && m_rdy(m);
      if (rst || flush) begin
        for (int l = 0; l < 4; l++) mq[m*4+l].delete();
        rr[m] = 0;
      end else begin
        for (int l = 0; l < 4; l++)
          if (m_occ(m, l) > 0 && rdy_out[l]) void'(mq[m*4+l].pop_front());
        if (acc) begin
          mq[m*4+d].push_back(data_in);
          if (m == 0) rr[0] = (rr[0] + 1) % 4;
        end
      end
    end
  endtask

  task automatic cycle_pre(input logic v, input logic [7:0] d, input logic [3:0] ro,
                           input logic fl);
    vld_in  = v;
    data_in = d;
    rdy_out = ro;
    flush   = fl;
    @(negedge clk);
    model_check();
  endtask

  task automatic cycle_post();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic [3:0] ro,
                       input logic fl);
    cycle_pre(v, d, ro, fl);
    cycle_post();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    vld_in = 1'b1;
    rst    = 1'b1;
    #1;
    model_clear();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst m%0d vld_out", m), 32'(vo_s[m]), 32'h0);
      chk($sformatf("rst m%0d idle", m), 32'(idle_s[m]), 32'h1);
      chk($sformatf("rst m%0d rdy_in", m), 32'(rdy_s[m]), 32'h0);
      chk($sformatf("rst m%0d dispatch_lane", m), 32'(dl_s[m]), 32'h0);
      chk($sformatf("rst m%0d lane_occ", m), 32'(occ_s[m]), 32'h0);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    vld_in = 1'b0;
  endtask

  typedef struct {
    logic        vld;
    logic [7:0]  din;
    logic [3:0]  rout;
    logic        exp_rdy;
    logic [1:0]  exp_lane;
    logic [11:0] exp_occ;
    logic [3:0]  exp_vld;
    logic        chk_h2;
    logic [7:0]  exp_h2;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst = 1'b1; flush = 1'b0; vld_in = 1'b0; data_in = '0; rdy_out = '0;
    model_clear();

    // Round-robin spread of 0x10..0x17, then drain lane 2.
    tbl[0]  = '{1'b1, 8'h10, 4'b0000, 1'b1, 2'd0, occ4(0,0,0,0), 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h11, 4'b0000, 1'b1, 2'd1, occ4(1,0,0,0), 4'b0001, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h12, 4'b0000, 1'b1, 2'd2, occ4(1,1,0,0), 4'b0011, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h13, 4'b0000, 1'b1, 2'd3, occ4(1,1,1,0), 4'b0111, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h14, 4'b0000, 1'b1, 2'd0, occ4(1,1,1,1), 4'b1111, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h15, 4'b0000, 1'b1, 2'd1, occ4(2,1,1,1), 4'b1111, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h16, 4'b0000, 1'b1, 2'd2, occ4(2,2,1,1), 4'b1111, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'h17, 4'b0000, 1'b1, 2'd3, occ4(2,2,2,1), 4'b1111, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 4'b0100, 1'b1, 2'd0, occ4(2,2,2,2), 4'b1111, 1'b1, 8'h12};
    tbl[9]  = '{1'b0, 8'h00, 4'b0100, 1'b1, 2'd0, occ4(2,2,1,2), 4'b1111, 1'b1, 8'h16};
    tbl[10] = '{1'b0, 8'h00, 4'b0000, 1'b1, 2'd0, occ4(2,2,0,2), 4'b1011, 1'b0, 8'h00};

    // Power-on reset, a few jobs, then reset mid-stream.
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 1), 4'b0000, 1'b0);
    apply_reset();
    cycle_pre(1'b0, 8'h00, 4'b0000, 1'b0);
    chk("release rdy_in", 32'(rdy_s[0]), 32'h1);
    chk("release dispatch_lane", 32'(dl_s[0]), 32'h0);
    cycle_post();

    foreach (tbl[i]) begin
      cycle_pre(tbl[i].vld, tbl[i].din, tbl[i].rout, 1'b0);
      chk($sformatf("tbl%0d rdy_in", i), 32'(rdy_s[0]), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d lane", i), 32'(dl_s[0]), 32'(tbl[i].exp_lane));
      chk($sformatf("tbl%0d occ", i), 32'(occ_s[0]), 32'(tbl[i].exp_occ));
      chk($sformatf("tbl%0d vld_out", i), 32'(vo_s[0]), 32'(tbl[i].exp_vld));
      if (tbl[i].chk_h2) chk($sformatf("tbl%0d head2", i), 32'(do_s[0][23:16]),
                             32'(tbl[i].exp_h2));
      cycle_post();
    end

    // Round-robin stall: lane 0 full blocks the input even when other lanes drain.
    apply_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + i), 4'b0000, 1'b0);
    cycle_pre(1'b1, 8'h77, 4'b0000, 1'b0);
    chk("stall rdy_in", 32'(rdy_s[0]), 32'h0);
    chk("stall lane", 32'(dl_s[0]), 32'h0);
    cycle_post();
    cycle_pre(1'b1, 8'h77, 4'b0010, 1'b0);
    chk("stall noskip rdy_in", 32'(rdy_s[0]), 32'h0);
    cycle_post();
    cycle_pre(1'b1, 8'h77, 4'b0001, 1'b0);
    chk("stall samecycle rdy_in", 32'(rdy_s[0]), 32'h0);
    cycle_post();
    cycle_pre(1'b1, 8'h78, 4'b0000, 1'b0);
    chk("stall freed rdy_in", 32'(rdy_s[0]), 32'h1);
    chk("stall freed lane", 32'(dl_s[0]), 32'h0);
    cycle_post();

    // Least-occupied: shape occupancies to {3,1,1,2}.
    apply_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h60 + i), 4'b0000, 1'b0);
    cycle(1'b0, 8'h00, 4'b1110, 1'b0);
    cycle(1'b0, 8'h00, 4'b0110, 1'b0);
    cycle_pre(1'b1, 8'h81, 4'b0000, 1'b0);
    chk("lo occ 3112", 32'(occ_s[1]), 32'(occ4(3,1,1,2)));
    chk("lo first lane", 32'(dl_s[1]), 32'h1);
    cycle_post();
    cycle_pre(1'b1, 8'h82, 4'b0000, 1'b0);
    chk("lo second lane", 32'(dl_s[1]), 32'h2);
    cycle_post();
    cycle_pre(1'b1, 8'h83, 4'b0000, 1'b0);
    chk("lo third lane", 32'(dl_s[1]), 32'h1);
    cycle_post();
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h90 + i), 4'b0000, 1'b0);
    cycle_pre(1'b1, 8'h99, 4'b0000, 1'b0);
    chk("lo all full rdy_in", 32'(rdy_s[1]), 32'h0);
    cycle_post();

    // Simultaneous push and pop on a lane holding DEPTH-1 entries.
    apply_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'hB0 + i), 4'b0000, 1'b0);
    cycle_pre(1'b1, 8'hA5, 4'b0001, 1'b0);
    chk("pushpop rdy_in", 32'(rdy_s[0]), 32'h1);
    cycle_post();
    cycle_pre(1'b0, 8'h00, 4'b0000, 1'b0);
    chk("pushpop occ0", 32'(occ_s[0][2:0]), 32'h3);
    cycle_post();
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 4'b1111, 1'b0);

    // Flush with five buffered jobs plus a concurrent push and pop.
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 4'b0000, 1'b0);
    cycle_pre(1'b1, 8'hEE, 4'b1111, 1'b1);
    chk("flush rdy_in", 32'(rdy_s[0]), 32'h0);
    cycle_post();
    cycle_pre(1'b0, 8'h00, 4'b0000, 1'b0);
    chk("flush occ", 32'(occ_s[0]), 32'h0);
    chk("flush vld_out", 32'(vo_s[0]), 32'h0);
    chk("flush idle", 32'(idle_s[0]), 32'h1);
    chk("flush rr_ptr", 32'(dl_s[0]), 32'h0);
    cycle_post();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hD0 + i), 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 4'b1111, 1'b0);

    // Randomised traffic with occasional flush and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom),
            $urandom_range(0, 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
